// File: rtl/uart_cfg_pkg.sv
// Shared encodings for the configurable UART: parity modes, FSM states, defaults.
package uart_cfg_pkg;

  localparam int unsigned DEF_OVERSAMPLE = 16;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // True when the mode carries a parity bit on the line.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running sample-tick generator: one tick every i_div+1 clocks.
module uart_baud_gen #(
  parameter int unsigned DIV_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_BIT-1:0] i_div,
  output logic               o_tick
);

  logic [DIV_BIT-1:0] cnt_q;

  // Count 0..i_div, pulse the tick on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else if (cnt_q >= i_div) begin
      cnt_q  <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + DIV_BIT'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: shared baud tick, oversampling RX and TX FSMs.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DIV_BIT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_BIT-1:0]   i_div,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_stop2,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done_tick,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done_tick
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV_BIT(DIV_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_div  (i_div),
    .o_tick (tick)
  );

  // ---------------- RX ----------------
  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [SW-1:0]        rx_scnt_q, rx_scnt_d;
  logic [NW-1:0]        rx_nbit_q, rx_nbit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           rx_mode_q, rx_mode_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_perr_d, rx_ferr_d, rx_done_d;

  // Two-flop synchronizer on the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next-state and datapath: mid-bit sampling, start-bit glitch rejection.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_scnt_d  = rx_scnt_q;
    rx_nbit_d  = rx_nbit_q;
    rx_shift_d = rx_shift_q;
    rx_mode_d  = rx_mode_q;
    rx_pbit_d  = rx_pbit_q;
    rx_data_d  = o_rx_data;
    rx_perr_d  = o_rx_parity_err;
    rx_ferr_d  = o_rx_frame_err;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_scnt_d  = '0;
          rx_mode_d  = i_parity_mode;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_scnt_q == S_HALF) begin
            rx_scnt_d = '0;
            rx_nbit_d = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_scnt_d = rx_scnt_q + SW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_scnt_q == S_FULL) begin
            rx_scnt_d  = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_nbit_q == N_LAST) begin
              rx_state_d = par_enabled(rx_mode_q) ? RX_PARITY : RX_STOP;
            end else begin
              rx_nbit_d = rx_nbit_q + NW'(1);
            end
          end else begin
            rx_scnt_d = rx_scnt_q + SW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_scnt_q == S_FULL) begin
            rx_scnt_d  = '0;
            rx_pbit_d  = rx_sync_q;
            rx_state_d = RX_STOP;
          end else begin
            rx_scnt_d = rx_scnt_q + SW'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_scnt_q == S_FULL) begin
            rx_scnt_d  = '0;
            rx_data_d  = rx_shift_q;
            rx_perr_d  = par_enabled(rx_mode_q) &&
                         (rx_pbit_q != ((^rx_shift_q) ^ (rx_mode_q == PAR_ODD)));
            rx_ferr_d  = !rx_sync_q;
            rx_done_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_scnt_d = rx_scnt_q + SW'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q      <= RX_IDLE;
      rx_scnt_q       <= '0;
      rx_nbit_q       <= '0;
      rx_shift_q      <= '0;
      rx_mode_q       <= PAR_NONE;
      rx_pbit_q       <= 1'b0;
      o_rx_data       <= '0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      o_rx_done_tick  <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      rx_scnt_q       <= rx_scnt_d;
      rx_nbit_q       <= rx_nbit_d;
      rx_shift_q      <= rx_shift_d;
      rx_mode_q       <= rx_mode_d;
      rx_pbit_q       <= rx_pbit_d;
      o_rx_data       <= rx_data_d;
      o_rx_parity_err <= rx_perr_d;
      o_rx_frame_err  <= rx_ferr_d;
      o_rx_done_tick  <= rx_done_d;
    end
  end

  // ---------------- TX ----------------
  logic [2:0]           tx_state_q, tx_state_d;
  logic [SW-1:0]        tx_scnt_q, tx_scnt_d;
  logic [NW-1:0]        tx_nbit_q, tx_nbit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_en_q, tx_par_en_d;
  logic                 tx_pbit_q, tx_pbit_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_second_q, tx_second_d;
  logic                 tx_d, tx_busy_d, tx_done_d;

  // TX next-state and line value; the line bit is chosen on each transition.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_scnt_d   = tx_scnt_q;
    tx_nbit_d   = tx_nbit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_en_d = tx_par_en_q;
    tx_pbit_d   = tx_pbit_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    tx_d        = o_tx;
    tx_busy_d   = o_tx_busy;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          tx_state_d  = TX_START;
          tx_scnt_d   = '0;
          tx_shift_d  = i_tx_data;
          tx_par_en_d = par_enabled(i_parity_mode);
          tx_pbit_d   = (^i_tx_data) ^ (i_parity_mode == PAR_ODD);
          tx_stop2_d  = i_stop2;
          tx_busy_d   = 1'b1;
          tx_d        = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_scnt_q == S_FULL) begin
            tx_scnt_d  = '0;
            tx_nbit_d  = '0;
            tx_state_d = TX_DATA;
            tx_d       = tx_shift_q[0];
          end else begin
            tx_scnt_d = tx_scnt_q + SW'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_scnt_q == S_FULL) begin
            tx_scnt_d  = '0;
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            if (tx_nbit_q == N_LAST) begin
              tx_second_d = 1'b0;
              if (tx_par_en_q) begin
                tx_state_d = TX_PARITY;
                tx_d       = tx_pbit_q;
              end else begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_nbit_d = tx_nbit_q + NW'(1);
              tx_d      = tx_shift_q[1];
            end
          end else begin
            tx_scnt_d = tx_scnt_q + SW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_scnt_q == S_FULL) begin
            tx_scnt_d   = '0;
            tx_second_d = 1'b0;
            tx_state_d  = TX_STOP;
            tx_d        = 1'b1;
          end else begin
            tx_scnt_d = tx_scnt_q + SW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_scnt_q == S_FULL) begin
            tx_scnt_d = '0;
            tx_d      = 1'b1;
            if (tx_stop2_q && !tx_second_q) begin
              tx_second_d = 1'b1;
            end else begin
              tx_state_d = TX_IDLE;
              tx_busy_d  = 1'b0;
              tx_done_d  = 1'b1;
            end
          end else begin
            tx_scnt_d = tx_scnt_q + SW'(1);
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_busy_d  = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q     <= TX_IDLE;
      tx_scnt_q      <= '0;
      tx_nbit_q      <= '0;
      tx_shift_q     <= '0;
      tx_par_en_q    <= 1'b0;
      tx_pbit_q      <= 1'b0;
      tx_stop2_q     <= 1'b0;
      tx_second_q    <= 1'b0;
      o_tx           <= 1'b1;
      o_tx_busy      <= 1'b0;
      o_tx_done_tick <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_scnt_q      <= tx_scnt_d;
      tx_nbit_q      <= tx_nbit_d;
      tx_shift_q     <= tx_shift_d;
      tx_par_en_q    <= tx_par_en_d;
      tx_pbit_q      <= tx_pbit_d;
      tx_stop2_q     <= tx_stop2_d;
      tx_second_q    <= tx_second_d;
      o_tx           <= tx_d;
      o_tx_busy      <= tx_busy_d;
      o_tx_done_tick <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: stimulus pushes expectations, monitors pop and compare.
module tb_uart_cfg;

  localparam int unsigned DB     = 8;
  localparam int unsigned DW     = 16;
  localparam int          DIV    = 4;
  localparam int          PER    = DIV + 1;
  localparam int          BITCLK = 16 * PER;

  typedef struct { logic [DB-1:0] data; bit perr; bit ferr; } rx_exp_t;
  typedef struct { int start_edge; int dur; } tx_exp_t;
  typedef struct { logic [15:0] bits; int len; bit skip; } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_div;
  logic [1:0]    i_parity_mode;
  logic          i_stop2;
  logic          rx_line;
  logic [DB-1:0] o_rx_data;
  logic          o_rx_done_tick, o_rx_parity_err, o_rx_frame_err;
  logic          i_tx_start;
  logic [DB-1:0] i_tx_data;
  logic          o_tx, o_tx_busy, o_tx_done_tick;
  logic          loop, rx_drv;

  assign rx_line = loop ? o_tx : rx_drv;

  uart_cfg #(.DATA_BITS(DB), .OVERSAMPLE(16), .DIV_BIT(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_div           (i_div),
    .i_parity_mode   (i_parity_mode),
    .i_stop2         (i_stop2),
    .i_rx            (rx_line),
    .o_rx_data       (o_rx_data),
    .o_rx_done_tick  (o_rx_done_tick),
    .o_rx_parity_err (o_rx_parity_err),
    .o_rx_frame_err  (o_rx_frame_err),
    .i_tx_start      (i_tx_start),
    .i_tx_data       (i_tx_data),
    .o_tx            (o_tx),
    .o_tx_busy       (o_tx_busy),
    .o_tx_done_tick  (o_tx_done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int c_rst  = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];
  frame_t  fr_q[$];

  function automatic void check(input bit ok, input string name, input string detail);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, detail);
  endfunction

  // Parity bit that makes the ones-count even (mode 01) or odd (mode 10).
  function automatic logic parity_of(input logic [DB-1:0] d, input logic [1:0] mode);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return (mode == 2'b01) ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  function automatic frame_t build_frame(input logic [DB-1:0] d, input logic [1:0] mode, input bit st2);
    frame_t f;
    int k = 0;
    f.bits = '1;
    f.skip = 1'b0;
    f.bits[k] = 1'b0; k++;
    for (int i = 0; i < DB; i++) begin f.bits[k] = d[i]; k++; end
    if (mode == 2'b01 || mode == 2'b10) begin f.bits[k] = parity_of(d, mode); k++; end
    f.bits[k] = 1'b1; k++;
    if (st2) begin f.bits[k] = 1'b1; k++; end
    f.len = k;
    return f;
  endfunction

  // RX result monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_rx_done_tick === 1'b1) begin
      rx_exp_t e;
      rx_done_cnt++;
      if (rx_q.size() == 0) begin
        check(1'b0, "rx_unexpected", $sformatf("done with data=%h, none expected", o_rx_data));
      end else begin
        e = rx_q.pop_front();
        check(o_rx_data == e.data && o_rx_parity_err == e.perr && o_rx_frame_err == e.ferr,
              "rx_frame", $sformatf("got data=%h perr=%b ferr=%b, want data=%h perr=%b ferr=%b",
              o_rx_data, o_rx_parity_err, o_rx_frame_err, e.data, e.perr, e.ferr));
      end
    end
  end

  // TX completion monitor: frame length in clocks and busy drop.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_tx_done_tick === 1'b1) begin
      tx_exp_t e;
      int d;
      tx_done_cnt++;
      if (tx_q.size() == 0) begin
        check(1'b0, "tx_unexpected_done", "done tick with no frame outstanding");
      end else begin
        e = tx_q.pop_front();
        d = cyc - e.start_edge;
        check(d >= e.dur - 1 && d <= e.dur + 1 && o_tx_busy == 1'b0, "tx_duration",
              $sformatf("got %0d clocks busy=%b, want %0d busy=0", d, o_tx_busy, e.dur));
      end
    end
  end

  // TX line decoder: samples each bit mid-period after a falling edge.
  initial begin
    bit prev;
    frame_t f;
    logic [15:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && prev && o_tx === 1'b0) begin
        if (fr_q.size() == 0) begin
          check(1'b0, "tx_unexpected_frame", "start bit seen with no frame outstanding");
        end else begin
          f = fr_q.pop_front();
          got = '1;
          repeat (BITCLK / 2) @(negedge clk);
          for (int j = 0; j < f.len; j++) begin
            if (j > 0) repeat (BITCLK) @(negedge clk);
            got[j] = o_tx;
          end
          if (!f.skip)
            check(got == f.bits, "tx_line", $sformatf("got bits %b, want %b", got, f.bits));
        end
      end
      prev = (o_tx !== 1'b0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_tx_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c_rst = cyc;
  endtask

  // Wait for a negedge whose following edge coincides with a baud tick.
  task automatic align();
    do @(negedge clk); while (((cyc - c_rst) % PER) != 0);
  endtask

  task automatic tx_send(input logic [DB-1:0] d, input logic [1:0] mode, input bit st2,
                         input bit chg, input bit restart);
    int n;
    frame_t f;
    tx_exp_t t;
    rx_exp_t r;
    n = 0;
    while (o_tx_busy && n < 3000) begin @(negedge clk); n++; end
    loop = 1'b1;
    align();
    f = build_frame(d, mode, st2);
    i_parity_mode = mode;
    i_stop2 = st2;
    i_tx_data = d;
    i_tx_start = 1'b1;
    t.start_edge = cyc + 1;
    t.dur = f.len * BITCLK;
    tx_q.push_back(t);
    fr_q.push_back(f);
    r.data = d; r.perr = 1'b0; r.ferr = 1'b0;
    rx_q.push_back(r);
    @(negedge clk);
    i_tx_start = 1'b0;
    n = 0;
    while (o_tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
      if (chg && n == 100) begin
        i_parity_mode = 2'($urandom);
        i_stop2 = 1'($urandom);
        i_tx_data = DB'($urandom);
      end
      if (restart && n == 300) begin i_tx_start = 1'b1; i_tx_data = ~d; end
      if (restart && n == 301) i_tx_start = 1'b0;
    end
    check(n >= t.dur - 1 && n <= t.dur + 1, "busy_span",
          $sformatf("busy high %0d clocks, want %0d", n, t.dur));
    repeat (100) @(negedge clk);
  endtask

  task automatic rx_drive(input logic [DB-1:0] d, input logic [1:0] mode, input bit flip,
                          input bit stopv);
    rx_exp_t e;
    bit pe;
    pe = (mode == 2'b01) || (mode == 2'b10);
    e.data = d; e.perr = pe && flip; e.ferr = !stopv;
    rx_q.push_back(e);
    loop = 1'b0;
    @(negedge clk);
    i_parity_mode = mode;
    rx_drv = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (pe) begin
      rx_drv = parity_of(d, mode) ^ flip;
      repeat (BITCLK) @(negedge clk);
    end
    rx_drv = stopv;
    repeat (stopv ? BITCLK : (3 * BITCLK) / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
  endtask

  initial begin
    int before_rx, before_tx;
    logic [DB-1:0] d;
    rst = 1'b1;
    i_div = DW'(DIV);
    i_parity_mode = 2'b00;
    i_stop2 = 1'b0;
    i_tx_start = 1'b0;
    i_tx_data = '0;
    loop = 1'b0;
    rx_drv = 1'b1;
    do_reset();

    check(o_tx == 1'b1, "rst_tx", $sformatf("got %b want 1", o_tx));
    check(o_tx_busy == 1'b0, "rst_busy", $sformatf("got %b want 0", o_tx_busy));
    check(o_tx_done_tick == 1'b0 && o_rx_done_tick == 1'b0, "rst_done",
          $sformatf("got tx=%b rx=%b want 0 0", o_tx_done_tick, o_rx_done_tick));
    check(o_rx_data == '0, "rst_rx_data", $sformatf("got %h want 00", o_rx_data));
    check(o_rx_parity_err == 1'b0 && o_rx_frame_err == 1'b0, "rst_flags",
          $sformatf("got perr=%b ferr=%b want 0 0", o_rx_parity_err, o_rx_frame_err));

    // Loopback 0xA5, no parity, one stop bit.
    tx_send(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0);
    // Even parity 0x07 loopback, then a wrong-parity RX frame.
    tx_send(8'h07, 2'b01, 1'b0, 1'b0, 1'b0);
    rx_drive(8'h07, 2'b01, 1'b1, 1'b1);
    // Two stop bits with an ignored mid-frame start request.
    tx_send(8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
    check(o_tx_busy == 1'b0, "no_requeue", $sformatf("busy=%b after frame, want 0", o_tx_busy));
    // Low stop bit.
    before_rx = rx_done_cnt;
    rx_drive(8'h3C, 2'b00, 1'b0, 1'b0);
    check(rx_done_cnt == before_rx + 1, "ferr_one_done",
          $sformatf("got %0d done ticks want 1", rx_done_cnt - before_rx));
    // Short start glitch, then a valid frame.
    loop = 1'b0;
    before_rx = rx_done_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (15) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check(rx_done_cnt == before_rx, "glitch_reject",
          $sformatf("got %0d done ticks want 0", rx_done_cnt - before_rx));
    rx_drive(8'h5A, 2'b10, 1'b0, 1'b1);

    // Reset during data bit 4 of a TX frame.
    loop = 1'b1;
    d = DB'($urandom);
    align();
    begin
      frame_t f;
      f = build_frame(d, 2'b00, 1'b0);
      f.skip = 1'b1;
      fr_q.push_back(f);
    end
    i_parity_mode = 2'b00; i_stop2 = 1'b0; i_tx_data = d; i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    repeat (440) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(o_tx == 1'b1 && o_tx_busy == 1'b0 && o_tx_done_tick == 1'b0, "mid_reset",
          $sformatf("got tx=%b busy=%b done=%b want 1 0 0", o_tx, o_tx_busy, o_tx_done_tick));
    rst = 1'b0;
    c_rst = cyc;
    before_rx = rx_done_cnt;
    before_tx = tx_done_cnt;
    repeat (1000) @(negedge clk);
    check(tx_done_cnt == before_tx && rx_done_cnt == before_rx, "abandoned_frame",
          $sformatf("got tx=%0d rx=%0d done ticks want 0 0",
          tx_done_cnt - before_tx, rx_done_cnt - before_rx));

    // Randomized loopback frames with mid-frame configuration churn.
    for (int k = 0; k < 10; k++)
      tx_send(DB'($urandom), 2'($urandom), 1'($urandom), 1'b1, 1'b0);

    // Randomized direct RX frames with occasional parity and stop errors.
    for (int k = 0; k < 6; k++)
      rx_drive(DB'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

    repeat (500) @(negedge clk);
    check(rx_q.size() == 0, "rx_drain", $sformatf("%0d rx frames never delivered", rx_q.size()));
    check(tx_q.size() == 0, "tx_drain", $sformatf("%0d tx frames never completed", tx_q.size()));
    check(fr_q.size() == 0, "line_drain", $sformatf("%0d tx frames never seen on line", fr_q.size()));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
